// File: rtl/matrices_addsub_int.sv
// rtl/matrices_addsub_int.sv - element-wise signed A+B / A-B matrix engine on a push/pop word bus
// Optional MATRICES_ADDSUB_SAT_EN clamps overflowing elements instead of wrapping.
module matrices_addsub_int #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 128,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_mode,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_ready,
  output logic                  o_res_avail,
  output logic                  o_error,
  output logic                  o_ovf
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_HDR = 3'd1,
    S_LOAD_A   = 3'd2,
    S_LOAD_B   = 3'd3,
    S_CALC     = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [AW-1:0]         cnt;
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         last_idx;
  logic                  mode;
  logic                  err_d;

  logic [DATA_WIDTH-1:0] mem_a   [DEPTH];
  logic [DATA_WIDTH-1:0] mem_b   [DEPTH];
  logic [DATA_WIDTH-1:0] mem_res [DEPTH];

  logic [CNT_WIDTH-1:0]  hdr_n;
  logic                  hdr_bad;
  logic [AW-1:0]         hdr_last;
  logic                  cnt_last;
  logic                  rd_last;

  logic [DATA_WIDTH-1:0] a_cur;
  logic [DATA_WIDTH-1:0] b_cur;
  logic [DATA_WIDTH:0]   a_ext;
  logic [DATA_WIDTH:0]   b_ext;
  logic [DATA_WIDTH:0]   full;
  logic                  calc_ovf;
  logic [DATA_WIDTH-1:0] res_val;

  assign hdr_n    = i_data[CNT_WIDTH-1:0];
  assign hdr_bad  = (hdr_n == '0) || (32'(hdr_n) > DEPTH);
  // N == DEPTH wraps the low bits to zero, so the decrement still lands on DEPTH-1
  assign hdr_last = hdr_n[AW-1:0] - AW'(1);
  assign cnt_last = (cnt == last_idx);
  assign rd_last  = (rd_ptr == last_idx);

  assign o_ready  = (state_q == S_IDLE);

  assign a_cur    = mem_a[cnt];
  assign b_cur    = mem_b[cnt];
  assign a_ext    = {a_cur[DATA_WIDTH-1], a_cur};
  assign b_ext    = {b_cur[DATA_WIDTH-1], b_cur};
  assign full     = mode ? (a_ext - b_ext) : (a_ext + b_ext);
  assign calc_ovf = full[DATA_WIDTH] ^ full[DATA_WIDTH-1];

`ifdef MATRICES_ADDSUB_SAT_EN
  // the extra top bit carries the sign of the true result
  assign res_val = !calc_ovf ? full[DATA_WIDTH-1:0] :
                   full[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                    : {1'b0, {(DATA_WIDTH-1){1'b1}}};
`else
  assign res_val = full[DATA_WIDTH-1:0];
`endif

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_push) state_d = S_LOAD_HDR;
      end
      S_LOAD_HDR: begin
        if (!i_push || hdr_bad) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          state_d = S_LOAD_A;
        end
      end
      S_LOAD_A: begin
        if (!i_push) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (cnt_last) begin
          state_d = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        if (!i_push) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (cnt_last) begin
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (cnt_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      o_data      <= '0;
      o_res_avail <= 1'b0;
      o_error     <= 1'b0;
      o_ovf       <= 1'b0;
      cnt         <= '0;
      rd_ptr      <= '0;
      last_idx    <= '0;
      mode        <= 1'b0;
    end else begin
      state_q <= state_d;
      o_error <= err_d;
      case (state_q)
        S_IDLE: begin
          // a simultaneous push takes priority and leaves the read side untouched
          if (!i_push && i_pop && o_res_avail) begin
            o_data <= mem_res[rd_ptr];
            if (rd_last) begin
              o_res_avail <= 1'b0;
              rd_ptr      <= '0;
            end else begin
              rd_ptr <= rd_ptr + AW'(1);
            end
          end
        end
        S_LOAD_HDR: begin
          if (i_push) begin
            last_idx    <= hdr_last;
            mode        <= i_mode;
            o_ovf       <= 1'b0;
            o_res_avail <= 1'b0;
            rd_ptr      <= '0;
            cnt         <= '0;
          end
        end
        S_LOAD_A, S_LOAD_B: begin
          if (i_push) cnt <= cnt_last ? '0 : cnt + AW'(1);
        end
        S_CALC: begin
          if (calc_ovf) o_ovf <= 1'b1;
          if (cnt_last) begin
            cnt         <= '0;
            o_res_avail <= 1'b1;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        default: begin
          o_res_avail <= 1'b0;
          cnt         <= '0;
          rd_ptr      <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (state_q == S_LOAD_A && i_push) mem_a[cnt] <= i_data;
    if (state_q == S_LOAD_B && i_push) mem_b[cnt] <= i_data;
    if (state_q == S_CALC)             mem_res[cnt] <= res_val;
  end

endmodule

// File: doc/matrices_addsub_int.md
Name: matrices_addsub_int

Overview:
- Parametrised successor to the integer matrix-sum engine: element-wise A+B or A-B on two signed matrices streamed in as flat word sequences.
- Adds a runtime add/sub mode, range checking with an error flag, a sequential one-element-per-cycle compute pass, and overflow detection.
- Sits on the same push/pop word bus as the other matrix operators; results are read back word by word.

Parameters:
- DATA_WIDTH, 16, element and bus width; signed two's complement.
- DEPTH, 128, maximum elements per operand; power of 2, at least 2.
- CNT_WIDTH, 16, width of the header element-count word; must be ≤ DATA_WIDTH.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_push  in  1  input word valid; a job is one contiguous push burst.
- i_data  in  DATA_WIDTH  input word: header, then A elements, then B elements.
- i_mode  in  1  sampled with the header word only; 0 = A+B, 1 = A-B.
- i_pop  in  1  request next result word.
- o_data  out  DATA_WIDTH  registered result word.
- o_ready  out  1  1 = block accepts a new job.
- o_res_avail  out  1  1 = unread results remain.
- o_error  out  1  one-cycle pulse on a rejected or aborted job.
- o_ovf  out  1  sticky; set if any element overflowed in the current job.

Behaviour:
- Reset (async, i_rst_n = 0): state IDLE; o_data = 0, o_ready = 1, o_res_avail = 0, o_error = 0, o_ovf = 0; counters 0. Buffer contents are don't-care.
- State IDLE:
  - o_ready = 1.
  - i_push moves to LOAD_HDR. The word pushed in this cycle is not consumed.
  - i_pop with o_res_avail = 1: o_data <= res[rd_ptr] next cycle, rd_ptr++.
  - On popping the last element (rd_ptr == N-1): o_res_avail <= 0, rd_ptr <= 0.
  - i_pop with o_res_avail = 0: ignored; o_data holds its value.
- State LOAD_HDR:
  - i_push = 1: N <= i_data[CNT_WIDTH-1:0]; mode <= i_mode; o_ovf <= 0; o_res_avail <= 0; rd_ptr <= 0.
  - If N == 0 or N > DEPTH: o_error pulse, go to IDLE. Otherwise go to LOAD_A.
  - i_push = 0: o_error pulse, go to IDLE.
- State LOAD_A: store i_data into A[cnt] each pushed cycle. After the word at cnt == N-1, cnt <= 0 and go to LOAD_B.
- State LOAD_B: store into B[cnt]. After the word at cnt == N-1, cnt <= 0 and go to CALC.
- Push gap in LOAD_A or LOAD_B (i_push = 0): o_error pulse, go to IDLE. The job is discarded and o_res_avail stays 0.
- o_ready = 0 in every state other than IDLE.
- State CALC:
  - One element per cycle: res[cnt] <= A[cnt] ± B[cnt]; N cycles total.
  - i_push and i_pop are ignored during CALC.
  - After cnt == N-1: o_res_avail <= 1, go to IDLE.
  - Latency from the last B push to o_res_avail = 1 is N+1 cycles.
- Arithmetic:
  - Compute in DATA_WIDTH+1 bits.
  - Overflow means the result falls outside [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; it sets o_ovf.
  - Without the optional feature, the stored result is the low DATA_WIDTH bits (wrap).
- Push and pop in the same IDLE cycle: push wins. Pending results are invalidated when the header is accepted; the pop is ignored.
- A new job may start while results are unread; those results are lost.
- Reset mid-job returns to the reset state immediately.
- Illegal state encodings go to IDLE with o_res_avail = 0.

Optional Feature:
- Macro MATRICES_ADDSUB_SAT_EN.
- Defined: overflowing elements clamp to 2^(DATA_WIDTH-1)-1 or -2^(DATA_WIDTH-1) according to the sign of the true result; o_ovf is still set.
- Undefined: wrap-around result; o_ovf is still set.

Test Plan:
- Header 3, mode 0, A = {1, 2, 3}, B = {10, 20, 30} -> o_res_avail rises 4 cycles after the last push; pops return 11, 22, 33; o_res_avail falls with the third pop; o_ovf = 0.
- Header 2, mode 1, A = {5, -4}, B = {7, -4} -> pops return -2, 0.
- Header 1, mode 0, A = {32767}, B = {1} -> o_ovf = 1. Result is -32768 without MATRICES_ADDSUB_SAT_EN and 32767 with it.
- Header 0, then separately header 129 with DEPTH = 128 -> o_error pulses once for each, block returns to IDLE, o_res_avail = 0.
- Push burst dropped after 2 of 3 B words -> o_error pulse, o_ready = 1 next cycle; a following valid job computes correctly.
- Async reset asserted during CALC -> all outputs at reset values; a subsequent job with header 1, A = {4}, B = {4} returns 8.
